// File: rtl/prog_seq_detector_multi_if.sv
// Config, serial-in and hit-report bundle for the multi-pattern detector.
// hit_cnt exists only when PSD_HIT_COUNT_EN is defined.
interface prog_seq_detector_multi_if #(
   parameter int SEQ_W   = 5,
   parameter int NUM_PAT = 4,
   parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
   parameter int CNT_W   = 8
);
   logic               clr;
   logic               ovl_mode;
   logic               cfg_we;
   logic [IDX_W-1:0]   cfg_idx;
   logic [SEQ_W-1:0]   cfg_pat;
   logic [SEQ_W-1:0]   cfg_mask;
   logic               cfg_en;
   logic               din_valid;
   logic               din;
   logic [NUM_PAT-1:0] hit;
   logic               hit_any;
   logic [SEQ_W-1:0]   hist;
`ifdef PSD_HIT_COUNT_EN
   logic [CNT_W-1:0]   hit_cnt;
`endif

   modport master (
      output clr, ovl_mode, cfg_we, cfg_idx,
      output cfg_pat, cfg_mask, cfg_en,
      output din_valid, din,
`ifdef PSD_HIT_COUNT_EN
      input  hit_cnt,
`endif
      input  hit, hit_any, hist
   );

   modport slave (
      input  clr, ovl_mode, cfg_we, cfg_idx,
      input  cfg_pat, cfg_mask, cfg_en,
      input  din_valid, din,
`ifdef PSD_HIT_COUNT_EN
      output hit_cnt,
`endif
      output hit, hit_any, hist
   );
endinterface

// File: rtl/prog_seq_detector_multi.sv
// Multi-slot programmable serial sequence detector with masked patterns.
// Optional saturating hit counter enabled by PSD_HIT_COUNT_EN.
module prog_seq_detector_multi #(
   parameter int SEQ_W   = 5,
   parameter int NUM_PAT = 4,
   parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic resetn,
   prog_seq_detector_multi_if.slave bus
);
   localparam int FILL_W = $clog2(SEQ_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_W);

   logic [SEQ_W-1:0]   hist_q, hist_d, hist_sh;
   logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
   logic [NUM_PAT-1:0] hit_q, hit_d, match;
   logic               hit_any_q, hit_any_d;
   logic [SEQ_W-1:0]   pat_q  [NUM_PAT];
   logic [SEQ_W-1:0]   mask_q [NUM_PAT];
   logic [NUM_PAT-1:0] en_q;

   // Matching looks at the history as it will be after this bit.
   always_comb begin
      hist_sh  = {hist_q[SEQ_W-2:0], bus.din};
      fill_inc = (fill_q == FILL_FULL) ? fill_q
                                       : fill_q + FILL_W'(1);
      for (int i = 0; i < NUM_PAT; i++) begin
         match[i] = bus.din_valid && en_q[i] &&
                    (fill_inc == FILL_FULL) &&
                    (((hist_sh ^ pat_q[i]) & mask_q[i]) == '0);
      end
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      hit_d  = '0;
      if (bus.clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (bus.din_valid) begin
         hit_d = match;
         if (!bus.ovl_mode && (|match)) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = hist_sh;
            fill_d = fill_inc;
         end
      end
      hit_any_d = |hit_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hist_q    <= '0;
         fill_q    <= '0;
         hit_q     <= '0;
         hit_any_q <= 1'b0;
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         hit_q     <= hit_d;
         hit_any_q <= hit_any_d;
      end
   end

   // Out-of-range indices match no slot and are dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en_q <= '0;
         for (int i = 0; i < NUM_PAT; i++) begin
            pat_q[i]  <= '0;
            mask_q[i] <= '0;
         end
      end else if (bus.cfg_we) begin
         for (int i = 0; i < NUM_PAT; i++) begin
            if (bus.cfg_idx == IDX_W'(i)) begin
               pat_q[i]  <= bus.cfg_pat;
               mask_q[i] <= bus.cfg_mask;
               en_q[i]   <= bus.cfg_en;
            end
         end
      end
   end

   assign bus.hit     = hit_q;
   assign bus.hit_any = hit_any_q;
   assign bus.hist    = hist_q;

`ifdef PSD_HIT_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (bus.clr) begin
         cnt_d = '0;
      end else if (hit_any_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.hit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_seq_detector_multi.sv
// Random and directed bench for prog_seq_detector_multi.
// Reference model keeps a bit window queue and slot tables.
module tb_prog_seq_detector_multi;
   localparam int SEQ_W   = 5;
   localparam int NUM_PAT = 3;
   localparam int IDX_W   = 2;
   localparam int CNT_W   = 8;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_total = 0;
   int   n_bad = 0;

   prog_seq_detector_multi_if #(
      .SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT),
      .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) bus ();

   prog_seq_detector_multi #(
      .SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT),
      .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   bit               win[$];
   logic [SEQ_W-1:0] m_pat  [NUM_PAT];
   logic [SEQ_W-1:0] m_mask [NUM_PAT];
   bit               m_en   [NUM_PAT];
   logic [NUM_PAT-1:0] e_hit;
   int               e_cnt;

   task automatic check(string tag,
                        logic [31:0] got,
                        logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [SEQ_W-1:0] m_hist();
      int v = 0;
      foreach (win[k]) v = v * 2 + int'(win[k]);
      return SEQ_W'(v);
   endfunction

   function automatic bit slot_match(int s);
      if (!m_en[s] || win.size() < SEQ_W) return 0;
      for (int k = 0; k < SEQ_W; k++) begin
         if (m_mask[s][SEQ_W-1-k] &&
             (m_pat[s][SEQ_W-1-k] != win[k]))
            return 0;
      end
      return 1;
   endfunction

   task automatic model_reset();
      win.delete();
      e_hit = '0;
      e_cnt = 0;
      for (int s = 0; s < NUM_PAT; s++) begin
         m_pat[s] = '0;
         m_mask[s] = '0;
         m_en[s] = 0;
      end
   endtask

   task automatic model_edge();
      e_hit = '0;
      if (bus.clr) begin
         win.delete();
         e_cnt = 0;
      end else if (bus.din_valid) begin
         win.push_back(bus.din);
         if (win.size() > SEQ_W) void'(win.pop_front());
         for (int s = 0; s < NUM_PAT; s++)
            e_hit[s] = slot_match(s);
         if (!bus.ovl_mode && (e_hit != 0)) win.delete();
         if ((e_hit != 0) && (e_cnt < CMAX)) e_cnt++;
      end
      if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_PAT)) begin
         m_pat[bus.cfg_idx]  = bus.cfg_pat;
         m_mask[bus.cfg_idx] = bus.cfg_mask;
         m_en[bus.cfg_idx]   = bus.cfg_en;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("hit", bus.hit, e_hit);
      check("hit_any", bus.hit_any, (e_hit != 0));
      check("hist", bus.hist, m_hist());
`ifdef PSD_HIT_COUNT_EN
      check("hit_cnt", bus.hit_cnt, e_cnt);
`endif
      bus.clr = 0;
      bus.cfg_we = 0;
      bus.din_valid = 0;
   endtask

   task automatic send(bit b);
      bus.din_valid = 1;
      bus.din = b;
      tick();
   endtask

   task automatic cfg(int idx, logic [SEQ_W-1:0] p,
                      logic [SEQ_W-1:0] m, bit e);
      bus.cfg_we = 1;
      bus.cfg_idx = IDX_W'(idx);
      bus.cfg_pat = p;
      bus.cfg_mask = m;
      bus.cfg_en = e;
      tick();
   endtask

   task automatic do_clr();
      bus.clr = 1;
      tick();
   endtask

   task automatic send_word(logic [SEQ_W-1:0] w, int n);
      for (int k = n - 1; k >= 0; k--) send(w[k]);
   endtask

   initial begin
      logic [SEQ_W-1:0] h;
      bus.clr = 0; bus.ovl_mode = 1; bus.cfg_we = 0;
      bus.cfg_idx = '0; bus.cfg_pat = '0;
      bus.cfg_mask = '0; bus.cfg_en = 0;
      bus.din_valid = 0; bus.din = 0;
      model_reset();
      #12 resetn = 1;
      #1;
      check("rst_hit", bus.hit, 0);
      check("rst_hist", bus.hist, 0);
      check("rst_any", bus.hit_any, 0);

      // Basic full-mask match, no early hit.
      cfg(0, 5'b10110, 5'b11111, 1);
      send_word(5'b1011, 4);
      check("t1_early", bus.hit, 0);
      send(0);
      check("t1_hit", bus.hit, 3'b001);
      check("t1_any", bus.hit_any, 1);
      tick();
      check("t1_pulse", bus.hit, 0);

      // Overlapping vs non-overlapping.
      do_clr();
      cfg(0, 5'b10101, 5'b11111, 1);
      send_word(5'b10101, 5);
      check("ovl_h5", bus.hit, 3'b001);
      send(0);
      send(1);
      check("ovl_h7", bus.hit, 3'b001);
      do_clr();
      bus.ovl_mode = 0;
      send_word(5'b10101, 5);
      check("novl_h5", bus.hit, 3'b001);
      send(0);
      send(1);
      check("novl_h7", bus.hit, 3'b000);
      bus.ovl_mode = 1;

      // Two slots hitting together, one masked.
      do_clr();
      cfg(0, 5'b00000, 5'b00000, 0);
      cfg(1, 5'b10001, 5'b10011, 1);
      cfg(2, 5'b10001, 5'b11111, 1);
      send_word(5'b10001, 5);
      check("multi_hit", bus.hit, 3'b110);
      check("multi_any", bus.hit_any, 1);
`ifdef PSD_HIT_COUNT_EN
      check("multi_cnt", bus.hit_cnt, 1);
`endif

      // Idle gaps between valid bits.
      do_clr();
      cfg(1, 5'b0, 5'b0, 0);
      cfg(2, 5'b0, 5'b0, 0);
      cfg(0, 5'b10110, 5'b11111, 1);
      for (int k = 4; k >= 0; k--) begin
         send(5'b10110 >> k);
         h = bus.hist;
         tick();
         tick();
         check("gap_hist", bus.hist, h);
         check("gap_nohit", bus.hit, 0);
      end
      check("gap_last", h, 5'b10110);

      // Config write alongside the completing bit.
      do_clr();
      send_word(5'b1011, 4);
      bus.cfg_we = 1; bus.cfg_idx = 0;
      bus.cfg_pat = 5'b00000;
      bus.cfg_mask = 5'b11111; bus.cfg_en = 1;
      send(0);
      check("cfg_old", bus.hit, 3'b001);
      send_word(5'b00000, 5);
      check("cfg_new", bus.hit, 3'b001);
      cfg(0, 5'b0, 5'b0, 0);
      cfg(3, 5'b0, 5'b0, 1);
      send(1);
      check("cfg_oob", bus.hit, 0);

      // Clear with the completing bit.
      cfg(0, 5'b10110, 5'b11111, 1);
      send_word(5'b1011, 4);
      bus.clr = 1;
      send(0);
      check("clr_hit", bus.hit, 0);
      check("clr_hist", bus.hist, 0);
`ifdef PSD_HIT_COUNT_EN
      check("clr_cnt", bus.hit_cnt, 0);
`endif

      // Async reset mid-stream.
      cfg(1, 5'b0, 5'b0, 1);
      send_word(5'b10110, 5);
      check("pre_rst", bus.hit, 3'b011);
      #2 resetn = 0;
      #1;
      check("arst_hit", bus.hit, 0);
      check("arst_any", bus.hit_any, 0);
      check("arst_hist", bus.hist, 0);
`ifdef PSD_HIT_COUNT_EN
      check("arst_cnt", bus.hit_cnt, 0);
`endif
      model_reset();
      #3 resetn = 1;
      send_word(5'b10110, 5);
      check("arst_dis", bus.hit, 0);

`ifdef PSD_HIT_COUNT_EN
      cfg(0, 5'b0, 5'b0, 1);
      for (int k = 0; k < CMAX + 20; k++)
         send(1'($urandom));
      check("cnt_sat", bus.hit_cnt, CMAX);
      do_clr();
`endif

      for (int n = 0; n < 1500; n++) begin
         bus.din_valid = ($urandom_range(0, 3) != 0);
         bus.din = 1'($urandom);
         bus.clr = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 40) == 0)
            bus.ovl_mode = 1'($urandom);
         if ($urandom_range(0, 12) == 0) begin
            bus.cfg_we = 1;
            bus.cfg_idx = IDX_W'($urandom_range(0, 3));
            bus.cfg_pat = SEQ_W'($urandom);
            bus.cfg_mask = SEQ_W'($urandom | $urandom);
            bus.cfg_en = ($urandom_range(0, 3) != 0);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d",
               n_total, n_bad);
      $finish;
   end
endmodule
